// File: rtl/logic_exec_stage.sv
// logic_exec_stage
//
// Execute-stage wrapper around a bitwise logic unit (AND/OR/XOR/NOT).
// Operations arrive from issue over a valid/ready handshake. Each result,
// its destination tag and its flags are held in a 2-entry output queue
// that feeds writeback. Throughput is one operation per cycle and latency
// is one cycle. A synchronous flush drops every queued result.
//
// Optional feature (macro LOGIC_PARITY_EN):
//   defined   - each entry stores the XOR-reduction of its result, shown on out_par.
//   undefined - no parity storage is built and out_par is tied low.
//   The port list is the same in both builds.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   flush             synchronous discard of all queued results
//   in_valid/in_ready issue handshake; in_ready depends only on registered occupancy
//   in_op             00 AND, 01 OR, 10 XOR, 11 NOT A
//   in_a, in_b        operands
//   in_tag            destination register tag
//   out_valid/ready   writeback handshake for the head entry
//   out_data/out_tag  head result and tag (zero when the queue is empty)
//   out_zero/neg/par  head flags (zero when the queue is empty)
//   op_count          number of results retired to writeback (wraps)
module logic_exec_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par,
  output logic [15:0]      op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
  } entry_t;

  logic [1:0]  count_q, count_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      new_entry;
  logic [15:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] result;
  logic        push, pop;

`ifdef LOGIC_PARITY_EN
  logic head_par_q, head_par_d;
  logic tail_par_q, tail_par_d;
  logic new_par;
`endif

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    result = '0;
    unique case (in_op)
      2'b00: result = in_a & in_b;
      2'b01: result = in_a | in_b;
      2'b10: result = in_a ^ in_b;
      2'b11: result = ~in_a;
      default: result = '0;
    endcase
  end

  always_comb begin
    new_entry      = '0;
    new_entry.data = result;
    new_entry.tag  = in_tag;
    new_entry.zero = (result == '0);
    new_entry.neg  = result[WIDTH-1];
  end

`ifdef LOGIC_PARITY_EN
  assign new_par = ^result;
`endif

  // Queue next state. Flush wins over any push/pop in the same cycle.
  // Push together with pop only happens at occupancy 1 (push needs < 2,
  // pop needs > 0), so the new entry simply replaces the head.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    op_count_d = op_count_q;
`ifdef LOGIC_PARITY_EN
    head_par_d = head_par_q;
    tail_par_d = tail_par_q;
`endif
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        op_count_d = op_count_q + 16'd1;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = new_entry;
`ifdef LOGIC_PARITY_EN
            head_par_d = new_par;
`endif
          end else begin
            tail_d = new_entry;
`ifdef LOGIC_PARITY_EN
            tail_par_d = new_par;
`endif
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Tail slides to head; when only one entry existed the stale
          // head is hidden by the output gating below.
          head_d  = tail_q;
`ifdef LOGIC_PARITY_EN
          head_par_d = tail_par_q;
`endif
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          head_d = new_entry;
`ifdef LOGIC_PARITY_EN
          head_par_d = new_par;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      op_count_q <= 16'd0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      op_count_q <= op_count_d;
    end
  end

`ifdef LOGIC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_par_q <= 1'b0;
      tail_par_q <= 1'b0;
    end else begin
      head_par_q <= head_par_d;
      tail_par_q <= tail_par_d;
    end
  end
  assign out_par = out_valid & head_par_q;
`else
  assign out_par = 1'b0;
`endif

  // Outputs read as zero whenever the queue is empty.
  assign out_data = out_valid ? head_q.data : '0;
  assign out_tag  = out_valid ? head_q.tag  : '0;
  assign out_zero = out_valid & head_q.zero;
  assign out_neg  = out_valid & head_q.neg;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_exec_stage.sv
// Self-checking bench for logic_exec_stage: directed cases plus a scoreboard
// of expected results, pushed on accepted issue and checked on retirement.
module tb_logic_exec_stage;

`ifdef LOGIC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_tag;
  logic        out_zero;
  logic        out_neg;
  logic        out_par;
  logic [15:0] op_count;

  logic_exec_stage #(.WIDTH(16), .TAG_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_par   (out_par),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  t;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      2'b00:   model = a & b;
      2'b01:   model = a | b;
      2'b10:   model = a ^ b;
      default: model = ~a;
    endcase
  endfunction

  // Handshakes are evaluated mid-cycle, where inputs and registered outputs
  // already hold the values the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            mon_e = sbq.pop_front();
            check("sb_data", {16'd0, out_data}, {16'd0, mon_e.d});
            check("sb_tag",  {29'd0, out_tag},  {29'd0, mon_e.t});
            check("sb_zero", {31'd0, out_zero}, {31'd0, (mon_e.d == 16'd0)});
            check("sb_neg",  {31'd0, out_neg},  {31'd0, mon_e.d[15]});
            check("sb_par",  {31'd0, out_par},  {31'd0, PAR_EN & (^mon_e.d)});
          end
          exp_cnt = exp_cnt + 16'd1;
        end
        if (in_valid && in_ready) begin
          sbq.push_back('{d: model(in_op, in_a, in_b), t: in_tag});
        end
      end
    end
  end

  // Presents one op and holds it until accepted; returns at edge+1.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] tag);
    bit acc;
    bit ok;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic head_is(input string tag, input logic [15:0] d, input logic [2:0] t,
                         input logic z, input logic n, input logic p);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {16'd0, out_data},  {16'd0, d});
    check({tag, "_tag"},   {29'd0, out_tag},   {29'd0, t});
    check({tag, "_zero"},  {31'd0, out_zero},  {31'd0, z});
    check({tag, "_neg"},   {31'd0, out_neg},   {31'd0, n});
    check({tag, "_par"},   {31'd0, out_par},   {31'd0, PAR_EN & p});
  endtask

  task automatic idle_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
    check({tag, "_data"},  {16'd0, out_data},  32'd0);
    check({tag, "_tag"},   {29'd0, out_tag},   32'd0);
    check({tag, "_flags"}, {29'd0, out_zero, out_neg, out_par}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved;
    int budget;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_a = 16'd0; in_b = 16'd0; in_tag = 3'd0;
    exp_cnt = 16'd0;
    #12;
    idle_zero("reset");
    check("reset_count", {16'd0, op_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ops, back-to-back with writeback always ready.
    out_ready = 1'b1;
    send(2'b00, 16'hF0F0, 16'hFF00, 3'd3);
    head_is("and", 16'hF000, 3'd3, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("and_count", {16'd0, op_count}, 32'd1);
    check("and_drained", {31'd0, out_valid}, 32'd0);
    send(2'b10, 16'h1234, 16'h1234, 3'd1);
    head_is("xor", 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0);
    send(2'b11, 16'h00FF, 16'hABCD, 3'd2);
    head_is("not", 16'hFF00, 3'd2, 1'b0, 1'b1, 1'b0);
    send(2'b01, 16'h0001, 16'h0002, 3'd4);
    head_is("or3", 16'h0003, 3'd4, 1'b0, 1'b0, 1'b0);
    send(2'b01, 16'h0001, 16'h0000, 3'd5);
    head_is("or1", 16'h0001, 3'd5, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("basic_count", {16'd0, op_count}, 32'd5);

    // Backpressure: two accepted, third held until the first pop.
    out_ready = 1'b0;
    send(2'b00, 16'hAAAA, 16'h0FF0, 3'd0);
    send(2'b01, 16'h1100, 16'h0011, 3'd1);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    head_is("bp_head", 16'h0AA0, 3'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_op = 2'b10; in_a = 16'hFFFF; in_b = 16'h8001; in_tag = 3'd2;
    repeat (2) begin
      @(posedge clk); #1;
      check("bp_held", {31'd0, in_ready}, 32'd0);
      check("bp_hold_data", {16'd0, out_data}, 32'h0AA0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_reready", {31'd0, in_ready}, 32'd1);
    head_is("bp_second", 16'h1111, 3'd1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    head_is("bp_third", 16'h7FFE, 3'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_count", {16'd0, op_count}, 32'd8);

    // Occupancy 1 with simultaneous push and pop.
    out_ready = 1'b0;
    send(2'b00, 16'h5555, 16'hFFFF, 3'd6);
    saved = exp_cnt;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b10; in_a = 16'h00F0; in_b = 16'h0F00; in_tag = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    head_is("pp", 16'h0FF0, 3'd7, 1'b0, 1'b0, 1'b0);
    check("pp_ready", {31'd0, in_ready}, 32'd1);
    check("pp_count", {16'd0, op_count}, {16'd0, saved + 16'd1});
    @(posedge clk); #1;
    check("pp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with a full queue and writeback ready.
    out_ready = 1'b0;
    send(2'b01, 16'h0F00, 16'h00F0, 3'd1);
    send(2'b11, 16'h0000, 16'h0000, 3'd2);
    check("fl_full", {31'd0, in_ready}, 32'd0);
    saved = exp_cnt;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle_zero("flush");
    check("flush_count", {16'd0, op_count}, {16'd0, saved});

    // Stream random ops until op_count reaches 0xFFFF, then wrap.
    budget = 70000;
    in_valid = 1'b1;
    while (exp_cnt != 16'hFFFF && budget > 0) begin
      in_op = 2'($urandom_range(0, 3));
      in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) check("wrap_timeout", 32'd0, 32'd1);
    check("wrap_max", {16'd0, op_count}, 32'h0000FFFF);
    check("wrap_pending", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check("wrap_zero", {16'd0, op_count}, 32'd0);
    check("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with a full queue, checked before any edge.
    out_ready = 1'b0;
    send(2'b01, 16'h8000, 16'h0001, 3'd3);
    send(2'b00, 16'hFFFF, 16'hFFFF, 3'd4);
    check("rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    idle_zero("async_rst");
    check("async_rst_count", {16'd0, op_count}, 32'd0);
    sbq.delete();
    exp_cnt = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b00, 16'h8421, 16'hFFFF, 3'd5);
    head_is("post_rst", 16'h8421, 3'd5, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("post_rst_count", {16'd0, op_count}, 32'd1);
    check("sb_leftover", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
